// File: rtl/apb_slave_mux_wdog.sv
// rtl/apb_slave_mux_wdog.sv - APB slave response mux with wait-state watchdog and illegal-select detection
// Optional error status (ERR_COUNT, LAST_ERR_SLV) enabled by APB_MUX_ERR_STATUS_EN.
module apb_slave_mux_wdog #(
    parameter int NUM_SLAVES     = 5,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic [NUM_SLAVES-1:0]        PSEL_VEC,
    input  logic                         PENABLE,
    input  logic [NUM_SLAVES-1:0]        PREADY_VEC,
    input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA_VEC,
    input  logic [NUM_SLAVES-1:0]        PSLVERR_VEC,
    output logic                         PREADY,
    output logic [DATA_W-1:0]            PRDATA,
    output logic                         PSLVERR,
    output logic                         TIMEOUT_EVT,
    output logic [7:0]                   ERR_COUNT,
    output logic [3:0]                   LAST_ERR_SLV
);

    localparam bit WD_EN  = (TIMEOUT_CYCLES > 0);
    localparam int WCNT_W = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WCNT_W-1:0] LIMIT = WCNT_W'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic {IDLE, ABORT} state_t;

    state_t                state_q, state_d;
    logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
    logic [NUM_SLAVES-1:0] prev_sel_q;
    logic                  timeout_evt_q;

    logic              sel_none, sel_legal, sel_illegal, sel_changed, stalled;
    logic              slv_ready, slv_err;
    logic [DATA_W-1:0] slv_data;

    always_comb begin
        sel_none    = (PSEL_VEC == '0);
        sel_legal   = ($countones(PSEL_VEC) == 1);
        sel_illegal = !sel_none && !sel_legal;
        slv_ready   = 1'b0;
        slv_err     = 1'b0;
        slv_data    = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (PSEL_VEC[i]) begin
                slv_ready = PREADY_VEC[i];
                slv_err   = PSLVERR_VEC[i];
                slv_data  = PRDATA_VEC[i*DATA_W +: DATA_W];
            end
        end
        // A select that moves to a different slave mid-transfer restarts the count
        sel_changed = (prev_sel_q != '0) && (PSEL_VEC != prev_sel_q);
        stalled     = sel_legal && PENABLE && !slv_ready;
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        PREADY  = 1'b1;
        PSLVERR = 1'b0;
        PRDATA  = '0;
        case (state_q)
            IDLE: begin
                if (sel_legal) begin
                    PREADY  = slv_ready;
                    PSLVERR = slv_err;
                    PRDATA  = slv_data;
                end else if (sel_illegal) begin
                    PSLVERR = 1'b1;
                end
                if (!WD_EN || PREADY || sel_none || sel_changed) begin
                    wcnt_d = '0;
                end else if (stalled) begin
                    if (wcnt_q == LIMIT) begin
                        state_d = ABORT;
                        wcnt_d  = '0;
                    end else begin
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                end
            end
            ABORT: begin
                PSLVERR = 1'b1;
                state_d = IDLE;
                wcnt_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= IDLE;
            wcnt_q        <= '0;
            prev_sel_q    <= '0;
            timeout_evt_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            prev_sel_q    <= PSEL_VEC;
            timeout_evt_q <= (state_q == ABORT);
        end
    end

    assign TIMEOUT_EVT = timeout_evt_q;

`ifdef APB_MUX_ERR_STATUS_EN
    logic [7:0] err_count_q;
    logic [3:0] last_err_slv_q;
    logic [3:0] sel_idx;
    logic       err_inc;

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (PSEL_VEC[i]) sel_idx = 4'(i);
        end
        err_inc = (state_q == ABORT) || (sel_illegal && PENABLE);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            err_count_q    <= '0;
            last_err_slv_q <= '0;
        end else begin
            if (err_inc && (err_count_q != 8'hFF)) err_count_q <= err_count_q + 8'd1;
            if (state_q == IDLE && state_d == ABORT) last_err_slv_q <= sel_idx;
        end
    end

    assign ERR_COUNT    = err_count_q;
    assign LAST_ERR_SLV = last_err_slv_q;
`else
    assign ERR_COUNT    = '0;
    assign LAST_ERR_SLV = '0;
`endif

endmodule

// File: tb/tb_apb_slave_mux_wdog.sv
// tb/tb_apb_slave_mux_wdog.sv - directed self-checking bench for apb_slave_mux_wdog
module tb_apb_slave_mux_wdog;

    localparam int NS = 5;
    localparam int DW = 32;
`ifdef APB_MUX_ERR_STATUS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic             PCLK = 1'b0;
    logic             PRESET;
    logic [NS-1:0]    PSEL_VEC;
    logic             PENABLE;
    logic [NS-1:0]    PREADY_VEC;
    logic [NS*DW-1:0] PRDATA_VEC;
    logic [NS-1:0]    PSLVERR_VEC;
    logic             PREADY;
    logic [DW-1:0]    PRDATA;
    logic             PSLVERR;
    logic             TIMEOUT_EVT;
    logic [7:0]       ERR_COUNT;
    logic [3:0]       LAST_ERR_SLV;

    int n_cmp = 0;
    int n_err = 0;

    apb_slave_mux_wdog #(.NUM_SLAVES(NS), .DATA_W(DW), .TIMEOUT_CYCLES(4)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL_VEC(PSEL_VEC), .PENABLE(PENABLE),
        .PREADY_VEC(PREADY_VEC), .PRDATA_VEC(PRDATA_VEC), .PSLVERR_VEC(PSLVERR_VEC),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR), .TIMEOUT_EVT(TIMEOUT_EVT),
        .ERR_COUNT(ERR_COUNT), .LAST_ERR_SLV(LAST_ERR_SLV)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // inputs are changed 1 time unit after the edge; outputs checked 2 units later
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk_bus(input string tag, input logic rdy, input logic err, input logic [31:0] dat);
        chk({tag, ".pready"}, 64'(PREADY), 64'(rdy));
        chk({tag, ".pslverr"}, 64'(PSLVERR), 64'(err));
        chk({tag, ".prdata"}, 64'(PRDATA), 64'(dat));
    endtask

    initial begin
        PRESET      = 1'b1;
        PSEL_VEC    = '0;
        PENABLE     = 1'b0;
        PREADY_VEC  = '0;
        PSLVERR_VEC = '0;
        PRDATA_VEC  = '0;
        PRDATA_VEC[0*DW +: DW] = 32'h1111_0000;
        PRDATA_VEC[1*DW +: DW] = 32'hDEAD_0001;
        PRDATA_VEC[2*DW +: DW] = 32'hA5A5_0001;
        PRDATA_VEC[3*DW +: DW] = 32'hC0DE_0003;
        PRDATA_VEC[4*DW +: DW] = 32'h4444_0004;
        tick(); tick();
        PRESET = 1'b0;
        settle();

        // reset state and idle bus
        chk("rst.evt", 64'(TIMEOUT_EVT), 64'd0);
        chk("rst.errcnt", 64'(ERR_COUNT), 64'd0);
        chk("rst.lastslv", 64'(LAST_ERR_SLV), 64'd0);
        chk_bus("idle", 1'b1, 1'b0, 32'h0);

        // slave 2 read, ready on first access cycle
        tick(); PSEL_VEC = 5'b00100; settle();
        tick(); PENABLE = 1'b1; PREADY_VEC = 5'b00100; settle();
        chk_bus("s2rd", 1'b1, 1'b0, 32'hA5A5_0001);
        tick(); PSEL_VEC = '0; PENABLE = 1'b0; PREADY_VEC = '0; settle();
        chk("s2rd.evt", 64'(TIMEOUT_EVT), 64'd0);

        // slave 1 stuck: 4 stalled cycles, abort, then event
        tick(); PSEL_VEC = 5'b00010; settle();
        tick(); PENABLE = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk($sformatf("to.stall%0d.pready", k), 64'(PREADY), 64'd0);
            chk($sformatf("to.stall%0d.evt", k), 64'(TIMEOUT_EVT), 64'd0);
            tick();
        end
        PREADY_VEC = 5'b00010; settle();
        chk_bus("to.abort", 1'b1, 1'b1, 32'h0);
        chk("to.abort.evt", 64'(TIMEOUT_EVT), 64'd0);
        tick(); PSEL_VEC = '0; PENABLE = 1'b0; PREADY_VEC = '0; settle();
        chk("to.evt", 64'(TIMEOUT_EVT), 64'd1);
        chk("to.errcnt", 64'(ERR_COUNT), ERR_EN ? 64'd1 : 64'd0);
        chk("to.lastslv", 64'(LAST_ERR_SLV), ERR_EN ? 64'd1 : 64'd0);
        tick(); settle();
        chk("to.evt_off", 64'(TIMEOUT_EVT), 64'd0);

        // slave 3 ready on the 4th stalled cycle wins over the watchdog
        tick(); PSEL_VEC = 5'b01000; settle();
        tick(); PENABLE = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk($sformatf("s3.stall%0d.pready", k), 64'(PREADY), 64'd0);
            tick();
        end
        PREADY_VEC = 5'b01000; PSLVERR_VEC = 5'b01000; settle();
        chk_bus("s3.done", 1'b1, 1'b1, 32'hC0DE_0003);
        tick(); PSEL_VEC = '0; PENABLE = 1'b0; PREADY_VEC = '0; PSLVERR_VEC = '0; settle();
        chk_bus("s3.after", 1'b1, 1'b0, 32'h0);
        chk("s3.evt", 64'(TIMEOUT_EVT), 64'd0);
        tick(); settle();
        chk("s3.evt2", 64'(TIMEOUT_EVT), 64'd0);
        chk("s3.errcnt", 64'(ERR_COUNT), ERR_EN ? 64'd1 : 64'd0);

        // illegal multi-select, slave responses must be ignored
        PSEL_VEC = 5'b00101; PENABLE = 1'b1; PREADY_VEC = 5'b00000; settle();
        chk_bus("ill", 1'b1, 1'b1, 32'h0);
        tick(); tick(); tick(); settle();
        chk("ill.errcnt3", 64'(ERR_COUNT), ERR_EN ? 64'd4 : 64'd0);
        chk("ill.evt", 64'(TIMEOUT_EVT), 64'd0);
        for (int k = 0; k < 297; k++) tick();
        settle();
        chk("ill.errsat", 64'(ERR_COUNT), ERR_EN ? 64'd255 : 64'd0);
        tick(); PSEL_VEC = '0; PENABLE = 1'b0; settle();
        chk("ill.errsat2", 64'(ERR_COUNT), ERR_EN ? 64'd255 : 64'd0);

        // reset on the 2nd stalled cycle drops the count: 4 fresh stalls needed
        tick(); PSEL_VEC = 5'b00010; settle();
        tick(); PENABLE = 1'b1; settle();
        tick(); PRESET = 1'b1; settle();
        tick(); PRESET = 1'b0; settle();
        chk("rs.errcnt", 64'(ERR_COUNT), 64'd0);
        chk("rs.evt", 64'(TIMEOUT_EVT), 64'd0);
        for (int k = 0; k < 4; k++) begin
            settle();
            chk($sformatf("rs.stall%0d.pready", k), 64'(PREADY), 64'd0);
            tick();
        end
        settle();
        chk_bus("rs.abort", 1'b1, 1'b1, 32'h0);
        tick(); PSEL_VEC = '0; PENABLE = 1'b0; settle();
        chk("rs.evt2", 64'(TIMEOUT_EVT), 64'd1);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
